// File: rtl/warning_scheduler.sv
// warning_scheduler
// Time-multiplexes three obstacle-warning speakers so that only one sounds at a time.
// Each raw sensor level is debounced. Active channels are then granted in round-robin
// order. Each grant lasts a fixed dwell and is followed by a silent gap.
//
// Optional feature macro: WARN_BEEP_EN. When it is defined, the granted speaker is pulsed
// 4 cycles on, 4 cycles off during the dwell. When it is undefined, the granted speaker
// is held solidly high for the whole dwell.
//
// Ports:
//   i_clk       single clock, rising edge
//   i_rst       synchronous active-high reset (overrides i_ena)
//   i_ena       clock enable; when low every register holds
//   i_sensor    raw LIDAR proximity levels, bit i = obstacle close in direction i
//   o_speaker   registered one-hot speaker enable, zero when silent
//   o_grant_id  channel currently or last granted, 3 when idle
//   o_active    registered debounced sensor levels
//   o_busy      high whenever the scheduler is not idle
module warning_scheduler #(
  parameter int unsigned DEB   = 4,
  parameter int unsigned DWELL = 16,
  parameter int unsigned GAP   = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ena,
  input  logic [2:0] i_sensor,
  output logic [2:0] o_speaker,
  output logic [1:0] o_grant_id,
  output logic [2:0] o_active,
  output logic       o_busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDwell = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;

  localparam logic [3:0] DebMax    = 4'(DEB);
  localparam logic [7:0] DwellLoad = 8'(DWELL - 1);
  localparam logic [3:0] GapLoad   = 4'(GAP - 1);

  logic [1:0]      r_state,   w_state;
  logic [2:0][3:0] r_cnt,     w_cnt;
  logic [2:0]      r_active,  w_active;
  logic [1:0]      r_last,    w_last;
  logic [1:0]      r_grant,   w_grant;
  logic [2:0]      r_speaker, w_speaker;
  logic [7:0]      r_dwell,   w_dwell;
  logic [3:0]      r_gap,     w_gap;

  // Debounce: a low sample clears the count and drops active on the same edge.
  always_comb begin
    w_cnt    = r_cnt;
    w_active = r_active;
    for (int i = 0; i < 3; i++) begin
      if (!i_sensor[i]) begin
        w_cnt[i] = 4'd0;
      end else if (r_cnt[i] == DebMax) begin
        w_cnt[i] = DebMax;
      end else begin
        w_cnt[i] = r_cnt[i] + 4'd1;
      end
      w_active[i] = (w_cnt[i] == DebMax);
    end
  end

  // Round-robin pick: rotate active so bit 0 is channel last+1, find the first set bit,
  // then map the offset back to a channel index modulo 3.
  logic [2:0] w_rot;
  logic [1:0] w_off;
  logic [2:0] w_sum;
  logic [1:0] w_sel;

  always_comb begin
    case (r_last)
      2'd0:    w_rot = {r_active[0], r_active[2], r_active[1]};
      2'd1:    w_rot = {r_active[1], r_active[0], r_active[2]};
      default: w_rot = r_active;
    endcase
    if (w_rot[0]) begin
      w_off = 2'd1;
    end else if (w_rot[1]) begin
      w_off = 2'd2;
    end else begin
      w_off = 2'd3;
    end
    w_sum = {1'b0, r_last} + {1'b0, w_off};
    w_sel = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
  end

  // A new grant starts from idle, or from the last gap cycle, whenever anything is active.
  logic w_start;
  assign w_start = (r_active != 3'b000) &&
                   ((r_state == StIdle) || ((r_state == StGap) && (r_gap == 4'd0)));

`ifdef WARN_BEEP_EN
  logic [7:0] w_elapsed;
`endif

  always_comb begin
    w_state   = r_state;
    w_last    = r_last;
    w_grant   = r_grant;
    w_speaker = r_speaker;
    w_dwell   = r_dwell;
    w_gap     = r_gap;
`ifdef WARN_BEEP_EN
    w_elapsed = 8'd0;
`endif
    case (r_state)
      StIdle: ;
      StDwell: begin
        // Only the granted channel's own active bit can cut the dwell short.
        if ((r_dwell == 8'd0) || !r_active[r_grant]) begin
          w_state   = StGap;
          w_speaker = 3'b000;
          w_gap     = GapLoad;
        end else begin
          w_dwell = r_dwell - 8'd1;
`ifdef WARN_BEEP_EN
          // Elapsed dwell count as of the coming edge; bit 2 gives the 4-on/4-off beat.
          w_elapsed = DwellLoad - w_dwell;
          w_speaker = w_elapsed[2] ? 3'b000 : 3'(3'b001 << r_grant);
`endif
        end
      end
      StGap: begin
        if (r_gap != 4'd0) begin
          w_gap = r_gap - 4'd1;
        end else if (r_active == 3'b000) begin
          w_state = StIdle;
          w_grant = 2'd3;
        end
      end
      default: begin
        w_state   = StIdle;
        w_speaker = 3'b000;
        w_grant   = 2'd3;
      end
    endcase
    if (w_start) begin
      w_state   = StDwell;
      w_last    = w_sel;
      w_grant   = w_sel;
      w_speaker = 3'(3'b001 << w_sel);
      w_dwell   = DwellLoad;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_active  <= 3'b000;
      r_last    <= 2'd2;
      r_grant   <= 2'd3;
      r_speaker <= 3'b000;
      r_dwell   <= 8'd0;
      r_gap     <= 4'd0;
    end else if (i_ena) begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_active  <= w_active;
      r_last    <= w_last;
      r_grant   <= w_grant;
      r_speaker <= w_speaker;
      r_dwell   <= w_dwell;
      r_gap     <= w_gap;
    end
  end

  assign o_speaker  = r_speaker;
  assign o_grant_id = r_grant;
  assign o_active   = r_active;
  assign o_busy     = (r_state != StIdle);

endmodule

// File: doc/warning_scheduler.md
# warning_scheduler

Time-multiplexes the three obstacle-warning speakers so only one sounds at a time, and each warning stays distinct. It takes the three raw LIDAR proximity levels from the pads and debounces each one. Active channels are granted in round-robin order, each for a fixed dwell, with a silent gap between grants. It sits between the `ui_in[2:0]` sensor pins and the `uo_out[2:0]` speaker pins, and replaces direct priority selection.

## Interface
- `DEB`, default 4: consecutive high samples needed before a sensor counts as active (1..15).
- `DWELL`, default 16: cycles a granted speaker stays on (2..255).
- `GAP`, default 2: silent cycles between grants (1..15).
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous and active-high. Overrides `ena`.
- `ena` in 1: when low, every register holds its value.
- `sensor` in 3: raw LIDAR levels; bit i high means an obstacle is close in direction i.
- `speaker` out 3: registered one-hot speaker enable; all-zero when silent.
- `grant_id` out 2: index of the channel currently or last selected; 2'd3 when idle.
- `active` out 3: registered, debounced sensor levels.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Debounce, per channel:**
  - A saturating counter `cnt[i]` is cleared on any low sample and incremented on each high sample, saturating at `DEB`.
  - `active[i]` = (`cnt[i]` == `DEB`), registered.
  - A low sample deasserts `active[i]` on that same edge.
- **Round-robin pointer `last`:**
  - Resets to 2, so the first scan starts at channel 0.
  - Selection is the first set bit of `active` scanning from `last+1`, wrapping 2→0.
  - `last` is updated to the selected index on every grant.
- **FSM states: IDLE, DWELL, GAP.**
- **IDLE:**
  - `speaker` = 0, `grant_id` = 3.
  - If `active` != 0, select a channel and go to DWELL. In the same edge, set `speaker` = onehot(sel) and load the dwell counter with `DWELL-1`.
- **DWELL:**
  - Each cycle, decrement the dwell counter.
  - Go to GAP when the counter is 0, or when `active[grant_id]` is low (early termination). Entering GAP clears `speaker` and loads the gap counter with `GAP-1`.
  - Changes to other channels' `active` bits do not preempt the current grant.
- **GAP:**
  - `speaker` = 0 and `grant_id` holds.
  - When the gap counter reaches 0:
    - if `active` != 0, select the next channel and go to DWELL;
    - otherwise go to IDLE with `grant_id` = 3.
  - With one lone active channel, that same channel is re-granted.
- **Reset:** `speaker` = 0, `active` = 0, `grant_id` = 3, `busy` = 0, all counters = 0, `last` = 2, state = IDLE. Applies mid-dwell or mid-gap with no extra cycle.
- **`ena` low:** all state is frozen, including debounce counters and the dwell/gap counts. Operation resumes exactly where it stopped.
- **Counter widths:**
  - dwell counter: 8 bits
  - gap counter and debounce counters: 4 bits
  - No wrap is possible within the legal parameter ranges.

## Timing
- **Assert latency:** with `sensor[i]` held high from idle, `active[i]` rises on the `DEB`-th sampling edge and `speaker[i]` rises on the (`DEB`+1)-th.
- **Dwell length:** `speaker` is high for exactly `DWELL` cycles, then low for exactly `GAP` cycles, before the next grant.
- **Early drop:** `speaker` clears on the edge after `active[grant_id]` falls.
- **Round-robin rotation:** from GAP, the next grant's `speaker` rises on the edge the gap counter hits 0 (a single edge, no IDLE detour).
- **Simultaneous sensor rise:** channels whose sensors rise together are granted in index order 0, 1, 2, then rotate.
- **Output timing:** all outputs are registered; there is no combinational path from `sensor` to `speaker`.

## Configuration
- **`WARN_BEEP_EN` defined:**
  - During DWELL, the granted speaker bit is pulsed with a 4-cycle-on / 4-cycle-off pattern, starting on at grant. It is derived from bit 2 of the elapsed-dwell count and stays registered.
  - Dwell length and grant timing are unchanged.
- **Not defined:** the granted speaker is held solidly high for the whole dwell.

## Test plan
Defaults: `DEB`=4, `DWELL`=16, `GAP`=2.
- **Reset:** `rst` high 2 cycles while `sensor`=3'b111 → `speaker`=0, `active`=0, `grant_id`=3, `busy`=0. After release, `speaker`=3'b001 on the 5th edge.
- **Single hold:** `sensor`=3'b001 held → `speaker`=3'b001 on for 16 cycles, 0 for 2 cycles, 3'b001 for 16 cycles, repeating.
- **Glitch:** `sensor[1]` high 3 cycles, then low → `active[1]` and `speaker` stay 0 throughout.
- **All active:** `sensor`=3'b111 held → `grant_id` sequence 0,1,2,0. Each grant is 16 cycles on with 2-cycle gaps, and `speaker` is never multi-hot.
- **Early drop / ena freeze:** `sensor[2]` drops at dwell cycle 5 with others low → `speaker` clears one edge after `active[2]` falls, then 2 gap cycles, then IDLE with `grant_id`=3. Separately, `ena` low for 10 cycles mid-dwell → outputs frozen, and the remaining dwell completes after `ena` returns.
- **`WARN_BEEP_EN` build:** single hold → per dwell, `speaker[0]` pattern is 4 on, 4 off, 4 on, 4 off, then a 2-cycle gap.
